// File: rtl/adc_serial_multi.sv
// Round-robin reader for serial ADC chips that share sclk/miso and have one active-low select each.
// Results are published per channel, each with a one-clk valid strobe.
module adc_serial_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int CLK_DIV    = 24,
  parameter int CS_SETUP   = 2,
  parameter int CONV_TICKS = 26,
  parameter int MSB_FIRST  = 1,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           miso,
  output logic                           sclk,
  output logic [CHANNELS-1:0]            sel,
  output logic [CHANNELS*DATA_WIDTH-1:0] value,
  output logic                           valid,
  output logic [CHW-1:0]                 valid_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  localparam logic [15:0] DIV_MAX   = 16'(CLK_DIV - 1);
  localparam logic [12:0] LIM_CONV  = 13'(CONV_TICKS - 1);
  localparam logic [12:0] LIM_SETUP = 13'(CS_SETUP - 1);
  localparam logic [12:0] LIM_SHIFT = 13'(2 * DATA_WIDTH - 1);

  state_t                          r_state, w_next;
  logic [15:0]                     r_div;
  logic [12:0]                     r_cnt, w_lim;
  logic                            w_tick, w_last;
  logic [CHW-1:0]                  r_ch, w_ch_inc, r_valid_ch;
  logic [DATA_WIDTH-1:0]           r_shift, w_shift_in;
  logic                            r_sclk, r_valid;
  logic [CHANNELS-1:0]             r_sel;
  logic [CHANNELS*DATA_WIDTH-1:0]  r_value;

  assign w_tick     = (r_div == '0);
  assign w_last     = w_tick && (r_cnt == w_lim);
  assign w_ch_inc   = (r_ch == CHW'(CHANNELS - 1)) ? '0 : r_ch + 1'b1;
  assign w_shift_in = (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], miso}
                                       : {miso, r_shift[DATA_WIDTH-1:1]};

  assign sclk     = r_sclk;
  assign sel      = r_sel;
  assign value    = r_value;
  assign valid    = r_valid;
  assign valid_ch = r_valid_ch;

  // Last-tick index of the current state; HOLD lasts a single tick.
  always_comb begin
    w_lim = '0;
    unique case (r_state)
      S_CONVERT: w_lim = LIM_CONV;
      S_SETUP:   w_lim = LIM_SETUP;
      S_SHIFT:   w_lim = LIM_SHIFT;
      default:   w_lim = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (enable) w_next = S_CONVERT;
      S_CONVERT: if (w_last) w_next = S_SETUP;
      S_SETUP:   if (w_last) w_next = S_SHIFT;
      S_SHIFT:   if (w_last) w_next = S_HOLD;
      S_HOLD:    if (w_last) w_next = enable ? S_CONVERT : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= DIV_MAX;
      r_cnt      <= '0;
      r_ch       <= '0;
      r_shift    <= '0;
      r_sclk     <= 1'b0;
      r_sel      <= '1;
      r_value    <= '0;
      r_valid    <= 1'b0;
      r_valid_ch <= '0;
    end else begin
      r_valid <= 1'b0;

      if (r_state == S_IDLE || w_tick) r_div <= DIV_MAX;
      else                             r_div <= r_div - 1'b1;

      if (w_next != r_state)                  r_cnt <= '0;
      else if (w_tick && r_state != S_IDLE)   r_cnt <= r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_sel  <= '1;
          r_sclk <= 1'b0;
        end
        S_CONVERT: if (w_last) r_sel <= ~(CHANNELS'(1) << r_ch);
        // Sample on the tick that raises sclk; the final toggle leaves sclk low.
        S_SHIFT: if (w_tick) begin
          r_sclk <= ~r_sclk;
          if (!r_sclk) r_shift <= w_shift_in;
        end
        S_HOLD: if (w_last) begin
          r_sel <= '1;
          for (int unsigned n = 0; n < CHANNELS; n++)
            if (CHW'(n) == r_ch) r_value[n*DATA_WIDTH +: DATA_WIDTH] <= r_shift;
          r_valid    <= 1'b1;
          r_valid_ch <= r_ch;
          r_ch       <= w_ch_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_multi.sv
// Directed bench for adc_serial_multi: four configurations driven by simple ADC chip models.
module tb_adc_serial_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // u0: defaults
  logic        rst0, en0, miso0, sclk0, valid0;
  logic [0:0]  sel0, vch0;
  logic [7:0]  value0;
  // u1: LSB-first, faster tick
  logic        rst1, en1, miso1, sclk1, valid1;
  logic [0:0]  sel1, vch1;
  logic [7:0]  value1;
  // u2: three 12-bit channels
  logic        rst2, en2, miso2, sclk2, valid2;
  logic [2:0]  sel2;
  logic [1:0]  vch2;
  logic [35:0] value2;
  // u3: tick every clk, minimal conversion and setup
  logic        rst3, en3, miso3, sclk3, valid3;
  logic [0:0]  sel3, vch3;
  logic [7:0]  value3;

  adc_serial_multi u0 (
    .clk(clk), .rst(rst0), .enable(en0), .miso(miso0), .sclk(sclk0), .sel(sel0),
    .value(value0), .valid(valid0), .valid_ch(vch0)
  );
  adc_serial_multi #(.CLK_DIV(4), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .miso(miso1), .sclk(sclk1), .sel(sel1),
    .value(value1), .valid(valid1), .valid_ch(vch1)
  );
  adc_serial_multi #(.DATA_WIDTH(12), .CHANNELS(3), .CLK_DIV(2), .CONV_TICKS(4)) u2 (
    .clk(clk), .rst(rst2), .enable(en2), .miso(miso2), .sclk(sclk2), .sel(sel2),
    .value(value2), .valid(valid2), .valid_ch(vch2)
  );
  adc_serial_multi #(.CLK_DIV(1), .CONV_TICKS(1), .CS_SETUP(1)) u3 (
    .clk(clk), .rst(rst3), .enable(en3), .miso(miso3), .sclk(sclk3), .sel(sel3),
    .value(value3), .valid(valid3), .valid_ch(vch3)
  );

  // Chip models: first bit presented when selected, next bit after each sclk fall.
  logic [7:0]  d0 = 8'h96, d1 = 8'h96, d3 = 8'hA5;
  logic [11:0] cur2;
  logic [2:0]  b0, b1, b3;
  logic [3:0]  b2;
  wire         desel2 = &sel2;

  always @(negedge sclk0 or posedge sel0[0]) if (sel0[0]) b0 = 3'd7; else if (b0 != 0) b0 = b0 - 1'b1;
  always @(negedge sclk1 or posedge sel1[0]) if (sel1[0]) b1 = 3'd7; else if (b1 != 0) b1 = b1 - 1'b1;
  always @(negedge sclk3 or posedge sel3[0]) if (sel3[0]) b3 = 3'd7; else if (b3 != 0) b3 = b3 - 1'b1;
  always @(negedge sclk2 or posedge desel2) if (desel2) b2 = 4'd11; else if (b2 != 0) b2 = b2 - 1'b1;

  always @* begin
    cur2 = '0;
    if (!sel2[0]) cur2 = 12'h123;
    if (!sel2[1]) cur2 = 12'h456;
    if (!sel2[2]) cur2 = 12'h789;
  end

  assign miso0 = d0[b0];
  assign miso1 = d1[b1];
  assign miso2 = cur2[b2];
  assign miso3 = d3[b3];

  int n, sl, bad, nv;
  logic v1;

  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1; rst3 = 1;
    en0 = 0; en1 = 0; en2 = 0; en3 = 0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk0, 0);
    check("rst_sel", sel0, 1);
    check("rst_value", value0, 0);
    check("rst_valid", valid0, 0);
    check("rst_vch", vch0, 0);
    check("rst_sel2", sel2, 3'b111);
    rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0;
    repeat (5) @(negedge clk);
    check("idle_sel", sel0, 1);
    check("idle_sclk", sclk0, 0);

    // Defaults: 0x96 MSB-first, frame period 45*24, select low 19*24
    en0 = 1;
    n = 0;
    while (!valid0 && n < 1500) begin @(negedge clk); n++; end
    check("A_valid", valid0, 1);
    check("A_value", value0, 8'h96);
    check("A_vch", vch0, 0);
    n = 0; sl = 0; v1 = 1'b1;
    do begin
      @(negedge clk); n++;
      if (n == 1) v1 = valid0;
      if (sel0 == 1'b0) sl++;
    end while (!valid0 && n < 1500);
    check("A_valid_1clk", v1, 0);
    check("A_period", n, 1080);
    check("A_sel_low", sl, 456);
    check("A_value2", value0, 8'h96);
    en0 = 0;

    // LSB-first of the same stream
    en1 = 1;
    n = 0;
    while (!valid1 && n < 400) begin @(negedge clk); n++; end
    check("B_valid", valid1, 1);
    check("B_value", value1, 8'h69);
    en1 = 0;

    // Three channels round-robin
    en2 = 1; bad = 0;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
        if ($countones(~sel2) > 1) bad++;
      end while (!valid2 && n < 200);
      check("C_valid", valid2, 1);
      check($sformatf("C_vch%0d", f), vch2, f % 3);
      if (f == 0) check("C_hold_others", value2, 36'h000000123);
    end
    check("C_onehot", bad, 0);
    check("C_value", value2, 36'h789456123);

    // Reset in the middle of the channel-1 frame
    n = 0;
    while (!sclk2 && n < 200) begin @(negedge clk); n++; end
    check("R_in_shift", sclk2, 1);
    #2 rst2 = 1;
    #1;
    check("R_sclk", sclk2, 0);
    check("R_sel", sel2, 3'b111);
    check("R_value", value2, 0);
    check("R_valid", valid2, 0);
    check("R_vch", vch2, 0);
    repeat (2) @(negedge clk);
    rst2 = 0;
    n = 0;
    while (!valid2 && n < 200) begin @(negedge clk); n++; end
    check("R_valid_after", valid2, 1);
    check("R_vch_after", vch2, 0);
    check("R_value_after", value2, 36'h000000123);
    en2 = 0;

    // One tick per clk: period 2*8+3
    en3 = 1;
    n = 0;
    while (!valid3 && n < 60) begin @(negedge clk); n++; end
    check("D_valid", valid3, 1);
    check("D_value", value3, 8'hA5);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid3 && n < 60);
    check("D_period", n, 19);
    check("D_value2", value3, 8'hA5);

    // Enable dropped during SHIFT: frame finishes, then idle
    n = 0;
    while (!sclk3 && n < 40) begin @(negedge clk); n++; end
    check("E_in_shift", sclk3, 1);
    en3 = 0;
    nv = 0;
    repeat (80) begin @(negedge clk); if (valid3) nv++; end
    check("E_one_valid", nv, 1);
    check("E_value", value3, 8'hA5);
    check("E_sel", sel3, 1);
    check("E_sclk", sclk3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
